// File: rtl/memctl_stream_if.sv
// memctl_stream_if: bundles the frame-control strobes, the source ROM read port,
// the destination RAM write port and the status outputs of memctl_stream.
// The master modport is the controller side; the slave modport is the environment side.
interface memctl_stream_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int SRC_ADDR_WIDTH = 15
);
  logic                      START_I;
  logic                      ABORT_I;
  logic [SRC_ADDR_WIDTH-1:0] SRC_ADDR_O;
  logic                      SRC_EN_O;
  logic [DATA_WIDTH-1:0]     SRC_DATA_I;
  logic [ADDR_WIDTH-1:0]     ADDRESS_O;
  logic [DATA_WIDTH-1:0]     DATA_O;
  logic                      WE_O;
  logic                      EN_O;
  logic                      DONE_O;
  logic                      BANK_O;
  logic [15:0]               FRAME_CNT_O;

  modport master (
    input  START_I, ABORT_I, SRC_DATA_I,
    output SRC_ADDR_O, SRC_EN_O, ADDRESS_O, DATA_O, WE_O, EN_O, DONE_O,
           BANK_O, FRAME_CNT_O
  );

  modport slave (
    output START_I, ABORT_I, SRC_DATA_I,
    input  SRC_ADDR_O, SRC_EN_O, ADDRESS_O, DATA_O, WE_O, EN_O, DONE_O,
           BANK_O, FRAME_CNT_O
  );
endinterface

// File: rtl/memctl_stream.sv
// memctl_stream: on START, copies one frame of NUM_CH*NUM_SAMPLE interleaved words
// from a synchronous source ROM into a sample RAM, laid out channel-major.
// The source pointer persists across frames; an abort rewinds it to the frame start.
// The ROM has one cycle of read latency and the write data is registered, so every
// write trails its read by two cycles.
// Optional ping-pong banking: define MEMCTL_STREAM_PINGPONG_EN to put BANK_O in the
// ADDRESS_O MSB and toggle it at each completed frame.
module memctl_stream #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int SRC_ADDR_WIDTH = 15,
  parameter int SRC_DEPTH      = 32768,
  parameter int NUM_SAMPLE     = 512,
  parameter int NUM_CH         = 2
) (
  input  logic           CLOCK_I,
  input  logic           RESET_I,
  memctl_stream_if.master bus
);

  localparam int N   = NUM_CH * NUM_SAMPLE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [SRC_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      drn_q, drn_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]     cbase_q, cbase_d;
  logic                      issue, flush, frame_done;
  logic [ADDR_WIDTH-1:0]     cur_addr;

  // Two-stage in-flight tracker: [0] = read issued last cycle, [1] = write now.
  logic [1:0]                   vld_pipe_q;
  logic [1:0][ADDR_WIDTH-1:0]   addr_pipe_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [15:0]                  frame_cnt_q;

`ifdef MEMCTL_STREAM_PINGPONG_EN
  logic bank_q;
  // Bank bit replaces the address MSB; the frame fits in the lower half.
  assign cur_addr = {bank_q, cbase_q[ADDR_WIDTH-2:0] + idx_q[ADDR_WIDTH-2:0]};
  assign bus.BANK_O = bank_q;
`else
  assign cur_addr   = cbase_q + idx_q;
  assign bus.BANK_O = 1'b0;
`endif

  assign bus.SRC_EN_O    = (state_q == ISSUE);
  assign bus.SRC_ADDR_O  = ptr_q;
  assign bus.DONE_O      = (state_q == IDLE);
  assign bus.EN_O        = (state_q != IDLE);
  assign bus.WE_O        = vld_pipe_q[1];
  assign bus.ADDRESS_O   = addr_pipe_q[1];
  assign bus.DATA_O      = data_q;
  assign bus.FRAME_CNT_O = frame_cnt_q;

  // Next-state: frame sequencing, source pointer walk and de-interleave counters.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    drn_d      = drn_q;
    ch_d       = ch_q;
    idx_d      = idx_q;
    cbase_d    = cbase_q;
    issue      = 1'b0;
    flush      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START_I && !bus.ABORT_I) begin
          state_d = ISSUE;
          base_d  = ptr_q;
          cnt_d   = '0;
          ch_d    = '0;
          idx_d   = '0;
          cbase_d = '0;
        end
      end
      ISSUE: begin
        if (bus.ABORT_I) begin
          state_d = IDLE;
          ptr_d   = base_q;
          flush   = 1'b1;
        end else begin
          issue = 1'b1;
          ptr_d = (ptr_q == SRC_ADDR_WIDTH'(SRC_DEPTH - 1)) ? '0
                                                           : ptr_q + SRC_ADDR_WIDTH'(1);
          cnt_d = cnt_q + CW'(1);
          // Channel steps fastest; on wrap the sample index advances and the
          // running channel base returns to zero (no multiply needed).
          if (ch_q == CHW'(NUM_CH - 1)) begin
            ch_d    = '0;
            cbase_d = '0;
            idx_d   = idx_q + ADDR_WIDTH'(1);
          end else begin
            ch_d    = ch_q + CHW'(1);
            cbase_d = cbase_q + ADDR_WIDTH'(NUM_SAMPLE);
          end
          if (cnt_q == CW'(N - 1)) begin
            state_d = DRAIN;
            drn_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (bus.ABORT_I) begin
          state_d = IDLE;
          ptr_d   = base_q;
          flush   = 1'b1;
        end else if (drn_q) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end else begin
          drn_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, write pipeline and frame bookkeeping.
  always_ff @(posedge CLOCK_I) begin
    if (RESET_I) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      drn_q       <= 1'b0;
      ch_q        <= '0;
      idx_q       <= '0;
      cbase_q     <= '0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
`ifdef MEMCTL_STREAM_PINGPONG_EN
      bank_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      base_q         <= base_d;
      cnt_q          <= cnt_d;
      drn_q          <= drn_d;
      ch_q           <= ch_d;
      idx_q          <= idx_d;
      cbase_q        <= cbase_d;
      vld_pipe_q[0]  <= issue;
      vld_pipe_q[1]  <= vld_pipe_q[0] & ~flush;
      addr_pipe_q[0] <= cur_addr;
      addr_pipe_q[1] <= addr_pipe_q[0];
      if (vld_pipe_q[0])
        data_q <= bus.SRC_DATA_I;
      if (frame_done)
        frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef MEMCTL_STREAM_PINGPONG_EN
      if (frame_done)
        bank_q <= ~bank_q;
`endif
    end
  end

endmodule

// File: tb/tb_memctl_stream.sv
// tb_memctl_stream: directed checks of memctl_stream with NUM_CH=2, NUM_SAMPLE=4,
// a 20-word ROM holding ROM[i]=i, so source wrap occurs inside the third frame.
module tb_memctl_stream;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int SAW   = 5;
  localparam int DEPTH = 20;
  localparam int NS    = 4;
  localparam int NCH   = 2;
  localparam int N     = NS * NCH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_bank = 0;
  logic [DW-1:0] rom_q = '0;

  memctl_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_ADDR_WIDTH(SAW)) bus ();

  memctl_stream #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_ADDR_WIDTH(SAW),
    .SRC_DEPTH(DEPTH), .NUM_SAMPLE(NS), .NUM_CH(NCH)
  ) dut (
    .CLOCK_I(clk),
    .RESET_I(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle latency, contents equal to address.
  always @(posedge clk) if (bus.SRC_EN_O) rom_q <= 32'(bus.SRC_ADDR_O);
  assign bus.SRC_DATA_I = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input int exp_cnt);
    chk("idle_done",  32'(bus.DONE_O), 32'd1);
    chk("idle_en",    32'(bus.EN_O), 32'd0);
    chk("idle_we",    32'(bus.WE_O), 32'd0);
    chk("idle_srcen", 32'(bus.SRC_EN_O), 32'd0);
    chk("idle_cnt",   32'(bus.FRAME_CNT_O), 32'(exp_cnt));
    chk("idle_bank",  32'(bus.BANK_O), 32'(exp_bank));
  endtask

  // Runs one frame from IDLE, checking every cycle. abort_at>0 raises ABORT_I in
  // that cycle; hold keeps START_I high through the frame.
  task automatic run_frame(input int p0, input int exp_cnt, input bit hold, input int abort_at);
    int k;
    bus.START_I = 1'b1;
    step();
    if (!hold) bus.START_I = 1'b0;
    chk("cnt_in_frame", 32'(bus.FRAME_CNT_O), 32'(exp_cnt - 1));
    for (int t = 1; t <= N + 2; t++) begin
      chk("busy_done", 32'(bus.DONE_O), 32'd0);
      chk("busy_en",   32'(bus.EN_O), 32'd1);
      chk("src_en",    32'(bus.SRC_EN_O), 32'(t <= N));
      if (t <= N) chk("src_addr", 32'(bus.SRC_ADDR_O), 32'((p0 + t - 1) % DEPTH));
      chk("we", 32'(bus.WE_O), 32'(t >= 3));
      if (t >= 3) begin
        k = t - 3;
        chk("wr_addr", 32'(bus.ADDRESS_O), 32'((k % NCH) * NS + k / NCH + exp_bank * 8));
        chk("wr_data", bus.DATA_O, 32'((p0 + k) % DEPTH));
      end
      chk("bank", 32'(bus.BANK_O), 32'(exp_bank));
      if (t == abort_at) begin
        bus.ABORT_I = 1'b1;
        step();
        bus.ABORT_I = 1'b0;
        chk_idle(exp_cnt - 1);
        return;
      end
      step();
    end
`ifdef MEMCTL_STREAM_PINGPONG_EN
    exp_bank = 1 - exp_bank;
`endif
    chk_idle(exp_cnt);
  endtask

  initial begin
    bus.START_I = 1'b0;
    bus.ABORT_I = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_addr", 32'(bus.ADDRESS_O), 32'd0);
    chk("rst_data", bus.DATA_O, 32'd0);
    chk("rst_src",  32'(bus.SRC_ADDR_O), 32'd0);
    chk_idle(0);
    rst = 1'b0;
    step();

    // Frame from 0, then back-to-back from 8 with an abort at the 3rd write.
    run_frame(0, 1, 1'b0, 0);
    run_frame(8, 2, 1'b0, 5);
    // Retry re-reads from 8.
    run_frame(8, 2, 1'b0, 0);
    // Source wrap: 16..19,0..3.
    run_frame(16, 3, 1'b0, 0);

    // Abort beats start in IDLE.
    bus.START_I = 1'b1;
    bus.ABORT_I = 1'b1;
    step();
    bus.START_I = 1'b0;
    bus.ABORT_I = 1'b0;
    chk_idle(3);
    chk("ptr_after_wrap", 32'(bus.SRC_ADDR_O), 32'd4);

    // START held high: frames chain with one IDLE cycle, one count per frame.
    run_frame(4, 4, 1'b1, 0);
    run_frame(12, 5, 1'b0, 0);

    // Reset mid-frame.
    bus.START_I = 1'b1;
    step();
    bus.START_I = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_bank = 0;
    chk("mrst_addr", 32'(bus.ADDRESS_O), 32'd0);
    chk("mrst_data", bus.DATA_O, 32'd0);
    chk("mrst_src",  32'(bus.SRC_ADDR_O), 32'd0);
    chk_idle(0);
    run_frame(0, 1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/memctl_stream.md
Name: memctl_stream

Overview:
- Parametrised successor to the single-channel ROM-to-RAM sample loader.
- On START_I, streams one frame of NUM_CH*NUM_SAMPLE interleaved words from a synchronous source ROM into the decoder's sample RAM, de-interleaved channel-major.
- Sits between the compressed/PCM source ROM and the sample buffer RAM. Source pointer persists across frames, so successive STARTs walk the ROM.

Parameters:
DATA_WIDTH  32  word width, source and destination
ADDR_WIDTH  10  destination address width; must be >= clog2(NUM_CH*NUM_SAMPLE) (+1 when PINGPONG_EN)
SRC_ADDR_WIDTH  15  source ROM address width
SRC_DEPTH  32768  source words; pointer wraps SRC_DEPTH-1 -> 0
NUM_SAMPLE  512  samples per channel per frame
NUM_CH  2  interleaved channels (>=1, any integer)

Ports:
CLOCK_I  in  1  clock, rising edge
RESET_I  in  1  reset, synchronous, active-high
START_I  in  1  frame request; sampled only in IDLE
ABORT_I  in  1  cancel current frame
SRC_ADDR_O  out  SRC_ADDR_WIDTH  ROM read address
SRC_EN_O  out  1  ROM read enable
SRC_DATA_I  in  DATA_WIDTH  ROM data, valid 1 cycle after SRC_EN_O
ADDRESS_O  out  ADDR_WIDTH  destination RAM address
DATA_O  out  DATA_WIDTH  destination write data (registered)
WE_O  out  1  destination write enable
EN_O  out  1  destination enable, = ~DONE_O
DONE_O  out  1  high when idle
BANK_O  out  1  bank being filled / next to fill
FRAME_CNT_O  out  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- Reset (RESET_I=1 at clock edge, any state, including mid-frame): state IDLE; DONE_O=1, EN_O=0, WE_O=0, SRC_EN_O=0, SRC_ADDR_O=0, ADDRESS_O=0, DATA_O=0, BANK_O=0, FRAME_CNT_O=0, source pointer=0, pipeline cleared.
- States:
  - IDLE: DONE_O=1. START_I=1 & ABORT_I=0 -> ISSUE; latch frame_base = pointer.
  - ISSUE: N=NUM_CH*NUM_SAMPLE reads on N consecutive cycles, SRC_EN_O=1, SRC_ADDR_O=pointer, pointer++ with wrap. Last read issued -> DRAIN.
  - DRAIN: two cycles flushing the pipeline -> IDLE.
- Pipeline:
  - Read issued cycle c; SRC_DATA_I sampled at end of c+1.
  - DATA_O/WE_O/ADDRESS_O valid during c+2, so the write trails its read by 2 cycles.
  - A 2-stage valid/channel/index shift register tracks in-flight words.
- De-interleave: source word k (0-based in frame) -> ch = k mod NUM_CH, idx = k div NUM_CH. ADDRESS_O = ch*NUM_SAMPLE + idx (+ bank offset, see feature).
  - Computed with ch/idx counters and a running channel base: no divider, no multiplier.
  - ch wraps NUM_CH-1 -> 0 and increments idx.
- Frame timing: START accepted at edge 0. Reads in cycles 1..N, writes in cycles 3..N+2. DONE_O=1 from cycle N+3. FRAME_CNT_O increments at the edge ending the last write.
- Back-to-back: START_I high in the first IDLE cycle starts the next frame. Pointer continues from frame_base+N mod SRC_DEPTH.
- START_I outside IDLE: ignored, not queued.
- ABORT_I=1 in ISSUE/DRAIN:
  - Next edge -> IDLE; WE_O and SRC_EN_O low from that cycle; in-flight words discarded.
  - Pointer restored to frame_base; no FRAME_CNT_O increment; no bank toggle.
- ABORT_I with START_I in IDLE: abort wins, stay IDLE.
- Source wrap mid-frame is legal; destination addresses are unaffected.

Optional Feature:
- Macro MEMCTL_STREAM_PINGPONG_EN.
- Defined:
  - ADDRESS_O MSB = BANK_O; lower bits as above.
  - BANK_O toggles at the edge completing a frame, so the consumer reads bank ~BANK_O while BANK_O fills.
  - An aborted frame keeps its bank.
- Undefined: BANK_O tied 0, no bank bit in ADDRESS_O, ADDRESS_O upper bits zero.

Test Plan:
- Reset, START pulse, NUM_CH=2, NUM_SAMPLE=4, ROM[i]=i -> SRC_ADDR_O 0..7 in cycles 1..8; writes cycles 3..10: (addr,data)=(0,0),(4,1),(1,2),(5,3),(2,4),(6,5),(3,6),(7,7); DONE_O=1 at cycle 11; FRAME_CNT_O=1.
- Second START right after first -> SRC_ADDR_O 8..15; data 8..15 at same address pattern; FRAME_CNT_O=2. With PINGPONG_EN, addresses +8 and BANK_O 0->1->0.
- SRC_DEPTH=16, pointer at 12, frame of 8 -> reads 12,13,14,15,0,1,2,3; next frame starts at 4.
- ABORT_I at 3rd write of frame starting at 8 -> WE_O low next cycle, DONE_O=1; FRAME_CNT_O and BANK_O unchanged; retry START re-reads from 8.
- START_I held high throughout -> frames run back to back, exactly one IDLE cycle between them; START_I during ISSUE ignored (count +1 per frame).
- RESET_I at mid-frame -> next cycle all outputs at reset values; subsequent START reads from address 0.
